// File: rtl/ssd_scan_decoder.sv
// Receive side of a multiplexed seven-segment display: samples the scanned anode/segment pair,
// decodes each digit back to BCD and emits one 4-digit frame per scan.
module ssd_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anode,
  input  logic [6:0]  led_out,
  output logic [15:0] value,
  output logic [3:0]  blank_mask,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] StableMax  = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] StableLast = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TmoMax     = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TmoLast    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StSync, StCapture, StEmit} state_e;

  state_e          state_q;
  logic [10:0]     sample_q;
  logic [SW-1:0]   stable_q;
  logic [TW-1:0]   tmo_q;
  logic [1:0]      expect_q;
  logic [15:0]     part_val_q;
  logic [3:0]      part_blank_q;

  logic       same, capture, an_idle, an_ok, seg_ok, seg_blank;
  logic       cap_dig, cap_bad_an, frame_bad;
  logic [1:0] dig;
  logic [3:0] nib;

  always_comb begin
    same    = ({anode, led_out} == sample_q);
    // Fires exactly once per dwell: the count saturates above StableLast until the input changes.
    capture = same && (stable_q == StableLast);

    an_idle = 1'b0;
    an_ok   = 1'b1;
    dig     = 2'd0;
    case (sample_q[10:7])
      4'b1110: dig = 2'd0;
      4'b1101: dig = 2'd1;
      4'b1011: dig = 2'd2;
      4'b0111: dig = 2'd3;
      4'b1111: begin
        an_ok   = 1'b0;
        an_idle = 1'b1;
      end
      default: an_ok = 1'b0;
    endcase

    seg_ok    = 1'b1;
    seg_blank = 1'b0;
    nib       = 4'd0;
    case (sample_q[6:0])
      7'b0000001: nib = 4'd0;
      7'b1001111: nib = 4'd1;
      7'b0010010: nib = 4'd2;
      7'b0000110: nib = 4'd3;
      7'b1001100: nib = 4'd4;
      7'b0100100: nib = 4'd5;
      7'b0100000: nib = 4'd6;
      7'b0001111: nib = 4'd7;
      7'b0000000: nib = 4'd8;
      7'b0000100: nib = 4'd9;
      7'b1111111: seg_blank = 1'b1;
      default:    seg_ok = 1'b0;
    endcase

    cap_dig    = capture && an_ok;
    cap_bad_an = capture && !an_ok && !an_idle;
    // All abort causes merge here, so coincident causes yield a single error pulse.
    frame_bad  = cap_bad_an || (cap_dig && (!seg_ok || (dig != expect_q))) ||
                 (!cap_dig && (tmo_q == TmoLast));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StSync;
      sample_q     <= '0;
      stable_q     <= '0;
      tmo_q        <= '0;
      expect_q     <= 2'd3;
      part_val_q   <= '0;
      part_blank_q <= '0;
      value        <= '0;
      blank_mask   <= '0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_q <= {anode, led_out};
      if (!same) begin
        stable_q <= SW'(1);
      end else if (stable_q != StableMax) begin
        stable_q <= stable_q + 1'b1;
      end

      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      case (state_q)
        StSync: begin
          tmo_q <= '0;
          if (cap_dig && seg_ok && (dig == 2'd3)) begin
            part_val_q[15:12] <= nib;
            part_blank_q[3]   <= seg_blank;
            expect_q          <= 2'd2;
            state_q           <= StCapture;
          end
        end
        StCapture: begin
          if (frame_bad) begin
            frame_err    <= 1'b1;
            part_val_q   <= '0;
            part_blank_q <= '0;
            tmo_q        <= '0;
            state_q      <= StSync;
          end else if (cap_dig) begin
            part_val_q[{dig, 2'b00} +: 4] <= nib;
            part_blank_q[dig]             <= seg_blank;
            tmo_q                         <= '0;
            if (dig == 2'd0) begin
              state_q <= StEmit;
            end else begin
              expect_q <= expect_q - 1'b1;
            end
          end else if (tmo_q != TmoMax) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StEmit: begin
          value       <= part_val_q;
          blank_mask  <= part_blank_q;
          frame_valid <= 1'b1;
          expect_q    <= 2'd3;
          tmo_q       <= '0;
          state_q     <= StCapture;
        end
        default: state_q <= StSync;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed self-checking bench for ssd_scan_decoder (STABLE_CYCLES=4, TIMEOUT_CYCLES=64).
module tb_ssd_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  anode;
  logic [6:0]  led_out;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic        frame_valid;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vcnt     = 0;
  int ecnt     = 0;
  int vcyc     = 0;
  int ecyc     = 0;
  int t0       = 0;
  int vbase, ebase;

  ssd_scan_decoder #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .anode      (anode),
    .led_out    (led_out),
    .value      (value),
    .blank_mask (blank_mask),
    .frame_valid(frame_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts every high cycle, so a stuck pulse shows up as an extra count.
  always @(negedge clk) begin
    if (frame_valid) begin
      vcnt <= vcnt + 1;
      vcyc <= cyc;
    end
    if (frame_err) begin
      ecnt <= ecnt + 1;
      ecyc <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n);
    anode   = an;
    led_out = sg;
    repeat (n) @(negedge clk);
  endtask

  // Digit value 10 means blank; t0 marks the cycle digit 0 appears.
  task automatic scan(input int d3, input int d2, input int d1, input int d0);
    drive(4'b0111, seg_of(d3), 8);
    drive(4'b1011, seg_of(d2), 8);
    drive(4'b1101, seg_of(d1), 8);
    t0 = cyc;
    drive(4'b1110, seg_of(d0), 8);
  endtask

  initial begin
    rst     = 1'b0;
    anode   = 4'hf;
    led_out = 7'h7f;
    repeat (3) @(negedge clk);
    check_val("rst_value", value, 16'h0000);
    check_val("rst_blank", blank_mask, 4'h0);
    check_val("rst_valid", frame_valid, 1'b0);
    check_val("rst_err", frame_err, 1'b0);
    rst = 1'b1;
    drive(4'hf, 7'h7f, 2);

    scan(1, 2, 3, 4);
    check_val("t2_value", value, 16'h1234);
    check_val("t2_blank", blank_mask, 4'h0);
    check_val("t2_vcnt", vcnt, 1);
    check_val("t2_latency", vcyc - t0, 5);
    check_val("t2_ecnt", ecnt, 0);

    scan(0, 0, 4, 2);
    check_val("t3_value_a", value, 16'h0042);
    check_val("t3_vcnt_a", vcnt, 2);
    scan(9, 9, 9, 9);
    check_val("t3_value_b", value, 16'h9999);
    check_val("t3_vcnt_b", vcnt, 3);
    check_val("t3_ecnt", ecnt, 0);

    scan(10, 10, 5, 7);
    check_val("t4_value", value, 16'h0057);
    check_val("t4_blank", blank_mask, 4'b1100);
    check_val("t4_vcnt", vcnt, 4);

    drive(4'b0111, seg_of(1), 8);
    drive(4'b1011, 7'b1110000, 8);
    check_val("t5_ecnt", ecnt, 1);
    check_val("t5_value_kept", value, 16'h0057);
    check_val("t5_vcnt", vcnt, 4);
    scan(8, 6, 0, 2);
    check_val("t5_value_next", value, 16'h8602);
    check_val("t5_blank_next", blank_mask, 4'h0);
    check_val("t5_vcnt_next", vcnt, 5);

    // Glitch after digit 2 is captured; the post-glitch remainder is shorter than the dwell.
    drive(4'b0111, seg_of(2), 8);
    drive(4'b1011, seg_of(5), 5);
    drive(4'b1011, 7'b1110000, 2);
    drive(4'b1011, seg_of(5), 3);
    drive(4'b1101, seg_of(7), 8);
    drive(4'b1110, seg_of(3), 8);
    check_val("t6_glitch_value", value, 16'h2573);
    check_val("t6_glitch_vcnt", vcnt, 6);
    check_val("t6_glitch_ecnt", ecnt, 1);

    drive(4'b0111, seg_of(3), 8);
    drive(4'b1101, seg_of(1), 8);
    check_val("t6_order_ecnt", ecnt, 2);
    check_val("t6_order_value", value, 16'h2573);

    drive(4'b0111, seg_of(4), 8);
    t0      = cyc;
    anode   = 4'b1011;
    led_out = seg_of(6);
    ebase   = ecnt;
    for (int i = 0; i < 200 && ecnt == ebase; i++) @(negedge clk);
    check_val("t6_tmo_ecnt", ecnt, ebase + 1);
    check_val("t6_tmo_time", ecyc - t0, 68);
    check_val("t6_tmo_vcnt", vcnt, 6);

    drive(4'hf, 7'h7f, 4);
    drive(4'b0111, seg_of(1), 8);
    drive(4'b1011, seg_of(2), 8);
    anode   = 4'b1101;
    led_out = seg_of(3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("t1_value", value, 16'h0000);
    check_val("t1_blank", blank_mask, 4'h0);
    check_val("t1_valid", frame_valid, 1'b0);
    check_val("t1_err", frame_err, 1'b0);
    vbase = vcnt;
    ebase = ecnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    drive(4'b1110, seg_of(4), 8);
    check_val("t1_no_valid", vcnt, vbase);
    check_val("t1_no_err", ecnt, ebase);
    check_val("t1_value_held", value, 16'h0000);

    scan(5, 0, 0, 9);
    check_val("t1_recover_value", value, 16'h5009);
    check_val("t1_recover_vcnt", vcnt, vbase + 1);
    check_val("t1_recover_ecnt", ecnt, ebase);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
